// File: rtl/dfi_chan_mux.sv
// N-channel SDR command/data mux between MMC channels and one shared DRAM PHY port.
// Define DFI_CHAN_MUX_FIXED_SLOT_EN for strict TDM slots instead of work-conserving round-robin.

`ifndef COMMON_STD_INTF_CNTL_SOM
`define COMMON_STD_INTF_CNTL_SOM 2'b01
`endif
`ifndef COMMON_STD_INTF_CNTL_MOM
`define COMMON_STD_INTF_CNTL_MOM 2'b00
`endif
`ifndef COMMON_STD_INTF_CNTL_EOM
`define COMMON_STD_INTF_CNTL_EOM 2'b10
`endif
`ifndef COMMON_STD_INTF_CNTL_SOM_EOM
`define COMMON_STD_INTF_CNTL_SOM_EOM 2'b11
`endif

module dfi_chan_mux #(
    parameter int unsigned NUM_CHANNELS = 2,
    parameter int unsigned DATA_WIDTH   = 256,
    parameter int unsigned BANK_WIDTH   = 2,
    parameter int unsigned ADDR_WIDTH   = 12,
    parameter int unsigned BURST_SIZE   = 4,
    parameter int unsigned TAG_DEPTH    = 8
) (
    input  logic                               clk,
    input  logic                               reset_poweron_n,
    output logic                               dfi__mmc__init_done,
    input  logic [NUM_CHANNELS-1:0]            mmc__dfi__req_valid,
    output logic [NUM_CHANNELS-1:0]            dfi__mmc__req_ready,
    input  logic [2*NUM_CHANNELS-1:0]          mmc__dfi__cmd,
    input  logic [BANK_WIDTH*NUM_CHANNELS-1:0] mmc__dfi__bank,
    input  logic [ADDR_WIDTH*NUM_CHANNELS-1:0] mmc__dfi__addr,
    input  logic [DATA_WIDTH*NUM_CHANNELS-1:0] mmc__dfi__data,
    output logic                               dfi__phy__cs,
    output logic                               dfi__phy__cmd1,
    output logic                               dfi__phy__cmd0,
    output logic [BANK_WIDTH-1:0]              dfi__phy__bank,
    output logic [ADDR_WIDTH-1:0]              dfi__phy__addr,
    output logic [DATA_WIDTH-1:0]              dfi__phy__data,
    input  logic                               phy__dfi__valid,
    input  logic [DATA_WIDTH-1:0]              phy__dfi__data,
    output logic [NUM_CHANNELS-1:0]            dfi__mmc__valid,
    output logic [2*NUM_CHANNELS-1:0]          dfi__mmc__cntl,
    output logic [DATA_WIDTH-1:0]              dfi__mmc__data,
    output logic                               dfi__sys__err
);

    localparam int unsigned CH_W   = $clog2(NUM_CHANNELS);
    localparam int unsigned PTR_W  = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(TAG_DEPTH + 1);
    localparam int unsigned BEAT_W = (BURST_SIZE > 1) ? $clog2(BURST_SIZE) : 1;

    localparam logic [1:0] CntlSom    = `COMMON_STD_INTF_CNTL_SOM;
    localparam logic [1:0] CntlMom    = `COMMON_STD_INTF_CNTL_MOM;
    localparam logic [1:0] CntlEom    = `COMMON_STD_INTF_CNTL_EOM;
    localparam logic [1:0] CntlSomEom = `COMMON_STD_INTF_CNTL_SOM_EOM;
    localparam logic [1:0] CmdRead    = 2'b01;

    logic [1:0]                   init_q;
    logic                         init_done;
    logic [CH_W-1:0]              tag_mem_q [TAG_DEPTH];
    logic [PTR_W-1:0]             wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]             cnt_q;
    logic [BEAT_W-1:0]            beat_q;
    logic                         err_q;
    logic                         cs_q;
    logic [1:0]                   cmd_q;
    logic [BANK_WIDTH-1:0]        bank_q;
    logic [ADDR_WIDTH-1:0]        addr_q;
    logic [DATA_WIDTH-1:0]        data_q;
    logic [NUM_CHANNELS-1:0]      rvalid_q;
    logic [2*NUM_CHANNELS-1:0]    rcntl_q;
    logic [DATA_WIDTH-1:0]        rdata_q;

    logic                         full, empty;
    logic [NUM_CHANNELS-1:0]      eligible;
    logic                         grant_vld;
    logic [CH_W-1:0]              grant_idx;
    logic [1:0]                   g_cmd;
    logic [BANK_WIDTH-1:0]        g_bank;
    logic [ADDR_WIDTH-1:0]        g_addr;
    logic [DATA_WIDTH-1:0]        g_data;
    logic                         push, pop, beat, err_set;
    logic [CH_W-1:0]              head;
    logic [1:0]                   beat_cntl;

    assign init_done = init_q[1];
    // Full is taken from registered occupancy, so a pop frees a slot only next cycle.
    assign full      = (cnt_q == CNT_W'(TAG_DEPTH));
    assign empty     = (cnt_q == '0);
    assign head      = tag_mem_q[rd_ptr_q];

    always_comb begin
        for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
            eligible[i] = mmc__dfi__req_valid[i] && init_done &&
                          !((mmc__dfi__cmd[2*i +: 2] == CmdRead) && full);
        end
    end

`ifdef DFI_CHAN_MUX_FIXED_SLOT_EN
    logic [CH_W-1:0] slot_q, slot_d;

    always_comb begin
        slot_d = slot_q;
        if (init_done) begin
            slot_d = (slot_q == CH_W'(NUM_CHANNELS - 1)) ? '0 : slot_q + 1'b1;
        end
        grant_idx = slot_q;
        grant_vld = eligible[slot_q];
    end

    always_ff @(posedge clk) begin
        if (!reset_poweron_n) slot_q <= '0;
        else                  slot_q <= slot_d;
    end
`else
    logic [CH_W-1:0] ptr_q, ptr_d;

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
            if (!grant_vld && eligible[(32'(ptr_q) + k) % NUM_CHANNELS]) begin
                grant_vld = 1'b1;
                grant_idx = CH_W'((32'(ptr_q) + k) % NUM_CHANNELS);
            end
        end
        ptr_d = ptr_q;
        if (grant_vld) begin
            ptr_d = (grant_idx == CH_W'(NUM_CHANNELS - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_poweron_n) ptr_q <= '0;
        else                  ptr_q <= ptr_d;
    end
`endif

    always_comb begin
        dfi__mmc__req_ready = '0;
        g_cmd  = '0;
        g_bank = '0;
        g_addr = '0;
        g_data = '0;
        for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
            if (grant_idx == CH_W'(i)) begin
                dfi__mmc__req_ready[i] = grant_vld;
                g_cmd  = mmc__dfi__cmd[2*i +: 2];
                g_bank = mmc__dfi__bank[BANK_WIDTH*i +: BANK_WIDTH];
                g_addr = mmc__dfi__addr[ADDR_WIDTH*i +: ADDR_WIDTH];
                g_data = mmc__dfi__data[DATA_WIDTH*i +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        push    = grant_vld && (g_cmd == CmdRead);
        beat    = phy__dfi__valid && !empty;
        err_set = phy__dfi__valid && empty;
        pop     = beat && (beat_q == BEAT_W'(BURST_SIZE - 1));
        if (BURST_SIZE == 1)                         beat_cntl = CntlSomEom;
        else if (beat_q == '0)                       beat_cntl = CntlSom;
        else if (beat_q == BEAT_W'(BURST_SIZE - 1))  beat_cntl = CntlEom;
        else                                         beat_cntl = CntlMom;
    end

    // Tag storage needs no reset: occupancy and pointers define what is live.
    always_ff @(posedge clk) begin
        if (push) tag_mem_q[wr_ptr_q] <= grant_idx;
    end

    always_ff @(posedge clk) begin
        if (!reset_poweron_n) begin
            init_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            beat_q   <= '0;
            err_q    <= 1'b0;
            cs_q     <= 1'b0;
            cmd_q    <= '0;
            bank_q   <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            rvalid_q <= '0;
            rcntl_q  <= {NUM_CHANNELS{CntlMom}};
            rdata_q  <= '0;
        end else begin
            init_q <= {init_q[0], 1'b1};
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
            if (beat) beat_q <= pop ? '0 : beat_q + 1'b1;
            if (err_set) err_q <= 1'b1;

            if (grant_vld) begin
                cs_q   <= (g_cmd != 2'b00);
                cmd_q  <= g_cmd;
                bank_q <= g_bank;
                addr_q <= g_addr;
                data_q <= g_data;
            end else begin
                cs_q  <= 1'b0;
                cmd_q <= '0;
            end

            rvalid_q <= '0;
            if (beat) begin
                rdata_q <= phy__dfi__data;
                for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
                    if (head == CH_W'(i)) begin
                        rvalid_q[i]       <= 1'b1;
                        rcntl_q[2*i +: 2] <= beat_cntl;
                    end
                end
            end
        end
    end

    assign dfi__mmc__init_done = init_done;
    assign dfi__phy__cs        = cs_q;
    assign dfi__phy__cmd1      = cmd_q[1];
    assign dfi__phy__cmd0      = cmd_q[0];
    assign dfi__phy__bank      = bank_q;
    assign dfi__phy__addr      = addr_q;
    assign dfi__phy__data      = data_q;
    assign dfi__mmc__valid     = rvalid_q;
    assign dfi__mmc__cntl      = rcntl_q;
    assign dfi__mmc__data      = rdata_q;
    assign dfi__sys__err       = err_q;

endmodule

// File: tb/tb_dfi_chan_mux.sv
// Randomized scoreboard bench for dfi_chan_mux with a queue-based reference model.
module tb_dfi_chan_mux;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int BW = 2;
    localparam int AW = 12;
    localparam int BS = 4;
    localparam int TD = 8;

    localparam logic [1:0] SOM = 2'b01, MOM = 2'b00, EOM = 2'b10, SOM_EOM = 2'b11;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              init_done;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [2*N-1:0]    cmd = '0;
    logic [BW*N-1:0]   bank = '0;
    logic [AW*N-1:0]   addr = '0;
    logic [DW*N-1:0]   wdata = '0;
    logic              cs, cmd1, cmd0;
    logic [BW-1:0]     phy_bank;
    logic [AW-1:0]     phy_addr;
    logic [DW-1:0]     phy_wdata;
    logic              phy_valid = 1'b0;
    logic [DW-1:0]     phy_rdata = '0;
    logic [N-1:0]      mmc_valid;
    logic [2*N-1:0]    mmc_cntl;
    logic [DW-1:0]     mmc_data;
    logic              sys_err;

    dfi_chan_mux #(
        .NUM_CHANNELS(N), .DATA_WIDTH(DW), .BANK_WIDTH(BW), .ADDR_WIDTH(AW),
        .BURST_SIZE(BS), .TAG_DEPTH(TD)
    ) dut (
        .clk(clk), .reset_poweron_n(rst_n), .dfi__mmc__init_done(init_done),
        .mmc__dfi__req_valid(req_valid), .dfi__mmc__req_ready(req_ready),
        .mmc__dfi__cmd(cmd), .mmc__dfi__bank(bank), .mmc__dfi__addr(addr),
        .mmc__dfi__data(wdata), .dfi__phy__cs(cs), .dfi__phy__cmd1(cmd1),
        .dfi__phy__cmd0(cmd0), .dfi__phy__bank(phy_bank), .dfi__phy__addr(phy_addr),
        .dfi__phy__data(phy_wdata), .phy__dfi__valid(phy_valid), .phy__dfi__data(phy_rdata),
        .dfi__mmc__valid(mmc_valid), .dfi__mmc__cntl(mmc_cntl), .dfi__mmc__data(mmc_data),
        .dfi__sys__err(sys_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int             due;
        logic [1:0]     c;
        logic [BW-1:0]  b;
        logic [AW-1:0]  a;
        logic [DW-1:0]  d;
    } cmd_exp_t;
    typedef struct {
        int             due;
        int             ch;
        logic [1:0]     cntl;
        logic [DW-1:0]  d;
    } ret_exp_t;

    cmd_exp_t cmd_sb[$];
    ret_exp_t ret_sb[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model state: what the DUT registers hold after the next edge.
    int m_ptr = 0, m_slot = 0, m_since = 0, m_beat = 0;
    bit m_err = 0;
    int m_tags[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_slot = 0; m_since = 0; m_beat = 0; m_err = 0;
        m_tags.delete();
    endtask

    // Evaluate the cycle: compare the combinational/sticky outputs, then advance the model.
    task automatic model_step();
        int g;
        bit mi;
        logic [1:0] c;
        logic [N-1:0] exp_rdy;
        ret_exp_t r;
        cmd_exp_t e;
        mi = (m_since >= 2);
        g = -1;
`ifdef DFI_CHAN_MUX_FIXED_SLOT_EN
        c = cmd[2*m_slot +: 2];
        if (mi && req_valid[m_slot] && !(c == 2'b01 && m_tags.size() == TD)) g = m_slot;
`else
        for (int k = 0; k < N; k++) begin
            int ch;
            ch = (m_ptr + k) % N;
            c = cmd[2*ch +: 2];
            if (g < 0 && mi && req_valid[ch] && !(c == 2'b01 && m_tags.size() == TD)) g = ch;
        end
`endif
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(exp_rdy));
        check("init_done", 64'(init_done), 64'(mi));
        check("sys_err", 64'(sys_err), 64'(m_err));
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (phy_valid) begin
            if (m_tags.size() == 0) begin
                m_err = 1;
            end else begin
                r.due = cyc + 1;
                r.ch  = m_tags[0];
                r.d   = phy_rdata;
                if (BS == 1)              r.cntl = SOM_EOM;
                else if (m_beat == 0)     r.cntl = SOM;
                else if (m_beat == BS-1)  r.cntl = EOM;
                else                      r.cntl = MOM;
                ret_sb.push_back(r);
                m_beat++;
                if (m_beat == BS) begin
                    m_beat = 0;
                    void'(m_tags.pop_front());
                end
            end
        end
        if (g >= 0) begin
            c = cmd[2*g +: 2];
            if (c == 2'b01) m_tags.push_back(g);
            if (c != 2'b00) begin
                e.due = cyc + 1;
                e.c = c;
                e.b = bank[BW*g +: BW];
                e.a = addr[AW*g +: AW];
                e.d = wdata[DW*g +: DW];
                cmd_sb.push_back(e);
            end
            m_ptr = (g + 1) % N;
        end
        if (mi) m_slot = (m_slot + 1) % N;
        if (m_since < 2) m_since++;
    endtask

    // One clock of stimulus: percentages for request valid, read/write mix and PHY beats.
    task automatic cycle(input bit rst, input int pv, input int prd, input int pwr,
                         input int pphy);
        @(negedge clk);
        rst_n = rst;
        for (int i = 0; i < N; i++) begin
            int r;
            r = $urandom_range(99);
            req_valid[i] = ($urandom_range(99) < pv);
            if (r < prd)            cmd[2*i +: 2] = 2'b01;
            else if (r < prd + pwr) cmd[2*i +: 2] = 2'b10;
            else if (r < 97)        cmd[2*i +: 2] = 2'b11;
            else                    cmd[2*i +: 2] = 2'b00;
            bank[BW*i +: BW]  = BW'($urandom);
            addr[AW*i +: AW]  = AW'($urandom);
            wdata[DW*i +: DW] = $urandom;
        end
        phy_valid = ($urandom_range(99) < pphy);
        phy_rdata = $urandom;
        #1;
        model_step();
    endtask

    // Monitor: pops the scoreboards whenever the DUT presents an output.
    initial begin
        bit r;
        cmd_exp_t e;
        ret_exp_t x;
        forever begin
            @(posedge clk);
            r = rst_n;
            #1;
            if (!r) begin
                check("rst_phy_cmd", {61'b0, cs, cmd1, cmd0}, 64'd0);
                check("rst_phy_fields", {phy_bank, phy_addr, phy_wdata}, 64'd0);
                check("rst_mmc_valid", 64'(mmc_valid), 64'd0);
                check("rst_mmc_cntl", 64'(mmc_cntl), 64'({N{MOM}}));
                check("rst_mmc_data", 64'(mmc_data), 64'd0);
            end else begin
                if (cs) begin
                    if (cmd_sb.size() == 0) begin
                        check("phy_unexpected_cs", 64'(cs), 64'd0);
                    end else begin
                        e = cmd_sb.pop_front();
                        check("phy_latency", 64'(cyc), 64'(e.due));
                        check("phy_cmd", {62'b0, cmd1, cmd0}, 64'(e.c));
                        check("phy_bank", 64'(phy_bank), 64'(e.b));
                        check("phy_addr", 64'(phy_addr), 64'(e.a));
                        check("phy_data", 64'(phy_wdata), 64'(e.d));
                    end
                end else begin
                    check("phy_idle_cmd", {62'b0, cmd1, cmd0}, 64'd0);
                    if (cmd_sb.size() != 0 && cmd_sb[0].due <= cyc) begin
                        check("phy_missing_cs", 64'(cs), 64'd1);
                        void'(cmd_sb.pop_front());
                    end
                end
                if (|mmc_valid) begin
                    if (ret_sb.size() == 0) begin
                        check("ret_unexpected_valid", 64'(mmc_valid), 64'd0);
                    end else begin
                        x = ret_sb.pop_front();
                        check("ret_latency", 64'(cyc), 64'(x.due));
                        check("ret_valid", 64'(mmc_valid), 64'(1) << x.ch);
                        check("ret_cntl", 64'(mmc_cntl[2*x.ch +: 2]), 64'(x.cntl));
                        check("ret_data", 64'(mmc_data), 64'(x.d));
                    end
                end else if (ret_sb.size() != 0 && ret_sb[0].due <= cyc) begin
                    check("ret_missing_valid", 64'(|mmc_valid), 64'd1);
                    void'(ret_sb.pop_front());
                end
            end
        end
    end

    initial begin
        int guard;
        repeat (2) @(posedge clk);
        // Reset with active requests: ready must stay low through init.
        repeat (5) cycle(1'b0, 100, 30, 30, 0);
        repeat (6) cycle(1'b1, 100, 0, 100, 0);
        // Error: beat with nothing outstanding.
        repeat (4) cycle(1'b1, 0, 0, 0, 0);
        cycle(1'b1, 0, 0, 0, 100);
        repeat (4) cycle(1'b1, 0, 0, 0, 0);
        repeat (3) cycle(1'b0, 0, 0, 0, 0);
        // All channels streaming writes.
        repeat (24) cycle(1'b1, 100, 0, 100, 0);
        // Read-heavy with no returns to hit the full condition.
        repeat (40) cycle(1'b1, 70, 70, 20, 0);
        repeat (100) cycle(1'b1, 100, 60, 30, 30);
        repeat (300) cycle(1'b1, 50, 40, 40, 50);
        // Reset with tags outstanding.
        repeat (2) cycle(1'b0, 50, 40, 40, 50);
        repeat (200) cycle(1'b1, 60, 50, 30, 40);
        guard = 0;
        while ((m_tags.size() != 0 || m_beat != 0) && guard < 200) begin
            cycle(1'b1, 0, 0, 0, 100);
            guard++;
        end
        repeat (4) cycle(1'b1, 0, 0, 0, 0);
        check("cmd_scoreboard_drained", 64'(cmd_sb.size()), 64'd0);
        check("ret_scoreboard_drained", 64'(ret_sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dfi_chan_mux.md
# dfi_chan_mux

Parameterised N-channel SDR command/data multiplexer between the main memory controller (MMC) and the single shared DRAM PHY port, on one clock. Arbitrates per-channel MMC requests onto the PHY command/write-data bus. Tracks outstanding reads in an in-order tag FIFO and routes PHY read-return beats back to the issuing channel with SOM/MOM/EOM framing. It is the next generation of the manager's DFI block: it generalises channel count, burst length and widths, and replaces clock-phase channel selection with explicit arbitration and read tagging.

## Interface
**Parameters**
- NUM_CHANNELS, 2, MMC channels sharing the PHY; at least 2.
- DATA_WIDTH, 256, PHY data width and per-channel data width.
- BANK_WIDTH, 2, bank address width.
- ADDR_WIDTH, 12, PHY address width.
- BURST_SIZE, 4, read-return beats per read command; at least 1.
- TAG_DEPTH, 8, outstanding-read FIFO depth; power of 2.

**Ports**
- clk  in  1  single clock for all logic.
- reset_poweron_n  in  1  synchronous, active-low reset.
- dfi__mmc__init_done  out  1  asserted 2 clk after reset deasserts.
- mmc__dfi__req_valid  in  NUM_CHANNELS  per-channel request valid.
- dfi__mmc__req_ready  out  NUM_CHANNELS  per-channel accept; a request is accepted when valid&ready.
- mmc__dfi__cmd  in  2*NUM_CHANNELS  per channel {cmd1,cmd0}: 01 = read, 10 = write, 11 = other, 00 = illegal.
- mmc__dfi__bank  in  BANK_WIDTH*NUM_CHANNELS  per-channel bank.
- mmc__dfi__addr  in  ADDR_WIDTH*NUM_CHANNELS  per-channel address.
- mmc__dfi__data  in  DATA_WIDTH*NUM_CHANNELS  per-channel write data.
- dfi__phy__cs, dfi__phy__cmd1, dfi__phy__cmd0  out  1 each  PHY command.
- dfi__phy__bank  out  BANK_WIDTH  PHY bank.
- dfi__phy__addr  out  ADDR_WIDTH  PHY address.
- dfi__phy__data  out  DATA_WIDTH  PHY write data.
- phy__dfi__valid  in  1  read-return beat valid.
- phy__dfi__data  in  DATA_WIDTH  read-return beat.
- dfi__mmc__valid  out  NUM_CHANNELS  per-channel return valid.
- dfi__mmc__cntl  out  2*NUM_CHANNELS  per-channel framing, encoded with the `COMMON_STD_INTF_CNTL_*` values.
- dfi__mmc__data  out  DATA_WIDTH  return data, shared by all channels and qualified by dfi__mmc__valid.
- dfi__sys__err  out  1  sticky error: return beat received with the tag FIFO empty.

## Operation
**Arbitration**
- One grant per cycle, chosen by a round-robin pointer of $clog2(NUM_CHANNELS) bits.
- The pointer advances to the grantee+1 after each grant and wraps at NUM_CHANNELS-1 → 0.
- dfi__mmc__req_ready is one-hot or zero and is combinational from req_valid, the pointer and the FIFO-full state.

**Read back-pressure**
- While the tag FIFO is full, read requests are ineligible for grant.
- Write and other requests remain eligible while the FIFO is full.

**Command issue**
- The accepted request is registered onto the PHY outputs: cs=1 plus its cmd, bank, addr and data.
- In a cycle with no grant, the PHY outputs are cs=0 and cmd=00; bank, addr and data hold their previous values.

**Read tagging**
- An accepted read pushes the channel id into the tag FIFO.
- A beat counter, 0..BURST_SIZE-1, counts phy__dfi__valid beats.
- The FIFO pops on the beat where the counter equals BURST_SIZE-1, and the counter wraps to 0.

**Return routing**
- Each beat is registered to channel = FIFO head: dfi__mmc__valid[head]=1, and dfi__mmc__data = the beat.
- cntl framing by beat counter:
  - count 0 → SOM;
  - count BURST_SIZE-1 → EOM;
  - otherwise → MOM;
  - BURST_SIZE==1 → SOM_EOM.
- A simultaneous push and pop are both honoured; occupancy is unchanged.

**Error handling**
- A beat arriving with the FIFO empty sets dfi__sys__err, drives no dfi__mmc__valid, and does not advance the counter.
- An illegal cmd (00) is accepted and issued with cs=0. It consumes the grant and is not tagged.

**Reset**
- Reset clears: the pointer, FIFO pointers and occupancy, the beat counter, and err.
- Reset mid-burst discards all outstanding tags.

## Timing
- Reset values:
  - all outputs 0, except dfi__mmc__cntl = MOM encoding;
  - dfi__mmc__init_done = 0 until 2 clk after reset_poweron_n rises.
- No grants are given while init_done = 0.
- Command latency: accept at cycle T → PHY outputs valid at T+1.
- Return latency: phy__dfi__valid at T → dfi__mmc__valid at T+1.
- Worst-case wait: a continuously valid requester is granted within NUM_CHANNELS cycles, unless it holds a read and the FIFO is full.
- FIFO full status is registered. A pop in cycle T frees space for a grant in cycle T+1, not in T.

## Configuration
- `DFI_CHAN_MUX_FIXED_SLOT_EN` defined: strict TDM.
  - Channel (slot counter mod NUM_CHANNELS) is the only eligible channel each cycle.
  - An idle slot issues cs=0.
  - Grant timing is deterministic, matching the previous-generation phase behaviour.
- Undefined: work-conserving round-robin as described in Operation.

## Test plan
- **Reset/init:** hold reset_poweron_n=0 for 5 clk, then release → init_done rises at release+2; all req_ready stay 0 until then.
- **Round-robin:** NUM_CHANNELS=4, all channels continuously request writes → grants 0,1,2,3,0,…; PHY cs=1 with cmd=10 on every cycle from the first grant+1.
- **Read return:** channel 1 reads, then channel 0 reads; 8 beats returned (BURST_SIZE=4) → ch1 valid with SOM,MOM,MOM,EOM, then ch0 with the same framing; data passes through unchanged.
- **FIFO full:** TAG_DEPTH=8, 8 reads issued with no returns → a 9th read is held off (ready=0) while a concurrent write from another channel is granted; the read is granted in the cycle after the first EOM pop.
- **Error:** phy__dfi__valid pulsed with no outstanding read → dfi__sys__err=1 and sticky; no dfi__mmc__valid.
- **Fixed-slot mode** (macro defined): only channel 2 requests, with NUM_CHANNELS=4 → grants occur exactly every 4th cycle.
